bin2bcd_seq: RTL

- Multi-cycle, parametrised binary-to-BCD converter using shift-and-add-3, one input bit per clock.
- Arbitrary input width and digit count, valid/ready handshakes on both sides, and a truncation overflow flag.
- Sits between game logic (score/guess counters) and the 7-segment display driver. Supersedes the 8-bit, 2-digit combinational converter for wide values.

---
 rtl/bin2bcd_pkg.sv | 17 +
 rtl/bcd_digit_adj.sv | 12 +
 rtl/bin2bcd_seq.sv | 128 ++++++++++++
 3 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // Decimal digits needed to hold 2^width-1 without overflow.
  // 2^w is never a power of ten for w >= 1, so floor(w*log10(2)) + 1 is exact.
  function automatic int unsigned min_digits(input int unsigned width);
    longint unsigned scaled;
    scaled = longint'(width) * 64'd30103;
    return int'(scaled / 64'd100000) + 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Per-digit add-3 correction for the shift-and-add-3 algorithm.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  // No carry into the next digit: a digit <= 9 stays <= 12 after correction.
  assign adj = (digit >= BCD_ADJ_THRESH) ? digit + BCD_ADJ_ADD : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Multi-cycle binary-to-BCD converter, one input bit per clock, with
// valid/ready on both sides and a truncation overflow flag.
// Optional macro BIN2BCD_BLANK_EN adds a registered leading-zero blank_mask.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned BIN_WIDTH = 16,
  parameter int unsigned DIGITS    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank_mask
`endif
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(BIN_WIDTH + 1);

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q;
  logic [BIN_WIDTH-1:0] shreg_q;
  logic [BcdW-1:0]      acc_q;
  logic                 ovf_acc_q;
  logic [BcdW-1:0]      bcd_q;
  logic                 ovf_q;

  logic [BcdW-1:0]      acc_adj;
  logic [BcdW-1:0]      acc_shift;
  logic                 carry;
  logic                 last_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (acc_q[4*g +: 4]),
      .adj   (acc_adj[4*g +: 4])
    );
  end

  // Shift {carry, bcd, shreg} left by one after the per-digit correction.
  assign acc_shift  = {acc_adj[BcdW-2:0], shreg_q[BIN_WIDTH-1]};
  assign carry      = acc_adj[BcdW-1];
  assign last_shift = (state_q == StShift) && (cnt_q == CntW'(1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid)             state_d = StShift;
      StShift: if (cnt_q == CntW'(1))    state_d = StDone;
      StDone:  if (out_ready)            state_d = StIdle;
      default:                           state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  // Datapath: capture, shift, and publish the result on the SHIFT->DONE edge only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      shreg_q   <= '0;
      acc_q     <= '0;
      ovf_acc_q <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else if (state_q == StIdle && in_valid) begin
      cnt_q     <= CntW'(BIN_WIDTH);
      shreg_q   <= bin_in;
      acc_q     <= '0;
      ovf_acc_q <= 1'b0;
    end else if (state_q == StShift) begin
      cnt_q     <= cnt_q - CntW'(1);
      shreg_q   <= shreg_q << 1;
      acc_q     <= acc_shift;
      ovf_acc_q <= ovf_acc_q | carry;
      if (last_shift) begin
        bcd_q <= acc_shift;
        ovf_q <= ovf_acc_q | carry;
      end
    end
  end

  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_d, blank_q;
  logic              higher_zero;

  // Digit i blanks when it and every digit above it are zero; digit 0 never blanks.
  always_comb begin
    blank_d     = '0;
    higher_zero = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      higher_zero = higher_zero && (acc_shift[4*i +: 4] == 4'd0);
      blank_d[i]  = higher_zero;
    end
  end

  // Blank mask register, updated together with bcd_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          blank_q <= '0;
    else if (last_shift) blank_q <= blank_d;
  end

  assign blank_mask = blank_q;
`endif

endmodule
